// File: rtl/bfpu_sched_pkg.sv
// rtl/bfpu_sched_pkg.sv - shared parameters and opcode encodings for the bfpu and its scheduler
package bfpu_sched_pkg;

    localparam int BIT_VEC_SIZE = 64;

    localparam logic [2:0] OP_SEL  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ANDN = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;

    // Encodings above OP_XOR are reserved and reported as errors.
    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/bfpu.sv
// rtl/bfpu.sv - single-cycle registered bit-vector function unit
module bfpu #(
    parameter int BIT_VEC_SIZE = bfpu_sched_pkg::BIT_VEC_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in_1,
    input  logic                    valid_in_2,
    input  logic [BIT_VEC_SIZE-1:0] in_1,
    input  logic [BIT_VEC_SIZE-1:0] in_2,
    input  logic [2:0]              opcode,
    input  logic                    choice,
    output logic                    valid_out,
    output logic [BIT_VEC_SIZE-1:0] data_out
);
    import bfpu_sched_pkg::*;

    logic [BIT_VEC_SIZE-1:0] result;

    // Combinational operation decode; reserved opcodes yield zero.
    always_comb begin
        result = '0;
        case (opcode)
            OP_SEL:  result = choice ? in_2 : in_1;
            OP_OR:   result = in_1 | in_2;
            OP_AND:  result = in_1 & in_2;
            OP_ANDN: result = in_1 & ~in_2;
            OP_XOR:  result = in_1 ^ in_2;
            default: result = '0;
        endcase
    end

    // Register the result one cycle after both operands are valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= valid_in_1 & valid_in_2;
            if (valid_in_1 & valid_in_2) begin
                data_out <= result;
            end
        end
    end

endmodule

// File: rtl/bfpu_sched.sv
// rtl/bfpu_sched.sv - round-robin scheduler sharing one bfpu among several requesters
module bfpu_sched #(
    parameter int NUM_REQ      = 4,
    parameter int BIT_VEC_SIZE = bfpu_sched_pkg::BIT_VEC_SIZE,
    parameter int TAG_W        = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*BIT_VEC_SIZE-1:0] req_in_1,
    input  logic [NUM_REQ*BIT_VEC_SIZE-1:0] req_in_2,
    input  logic [NUM_REQ*3-1:0]            req_opcode,
    input  logic [NUM_REQ-1:0]              req_choice,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [BIT_VEC_SIZE-1:0]         resp_data,
    output logic [TAG_W-1:0]                resp_id,
    output logic                            resp_err
);
    import bfpu_sched_pkg::*;

    logic [TAG_W-1:0]        rr_ptr;
    logic [TAG_W-1:0]        grant_idx;
    logic [TAG_W-1:0]        cand;
    logic                    any_req;
    logic                    credit_ok;
    logic                    accept;
    logic                    pop;
    logic                    push;
    logic [2:0]              sel_op;
    logic [BIT_VEC_SIZE-1:0] op_data;
    logic [TAG_W-1:0]        tag_q;
    logic                    err_q;

    logic [BIT_VEC_SIZE-1:0] fifo_data [2];
    logic [TAG_W-1:0]        fifo_id   [2];
    logic                    fifo_err  [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              fifo_count;

    // Cyclic search from rr_ptr for the first active requester.
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_req && req_valid[cand]) begin
                any_req   = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // The operation in the bfpu always lands in the FIFO next cycle, so it
    // is counted against the two slots together with the buffered entries.
    assign pop       = resp_valid & resp_ready;
    assign credit_ok = (3'(fifo_count) + 3'(push) - 3'(pop)) < 3'd2;
    assign accept    = any_req & credit_ok & ~rst;
    assign sel_op    = req_opcode[grant_idx*3 +: 3];

    // One-hot grant to the winning requester when a slot is available.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    bfpu #(
        .BIT_VEC_SIZE (BIT_VEC_SIZE)
    ) u_bfpu (
        .clk        (clk),
        .rst        (rst),
        .valid_in_1 (accept),
        .valid_in_2 (accept),
        .in_1       (req_in_1[grant_idx*BIT_VEC_SIZE +: BIT_VEC_SIZE]),
        .in_2       (req_in_2[grant_idx*BIT_VEC_SIZE +: BIT_VEC_SIZE]),
        .opcode     (sel_op),
        .choice     (req_choice[grant_idx]),
        .valid_out  (push),
        .data_out   (op_data)
    );

    // Pointer advance past the accepted requester, and the tag/error side
    // channel that travels alongside the bfpu pipeline stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            tag_q  <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            rr_ptr <= TAG_W'((int'(grant_idx) + 1) % NUM_REQ);
            tag_q  <= grant_idx;
            err_q  <= !op_legal(sel_op);
        end
    end

    // Two-entry result FIFO; errored results are stored as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= err_q ? '0 : op_data;
                fifo_id[wr_ptr]   <= tag_q;
                fifo_err[wr_ptr]  <= err_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign resp_valid = (fifo_count != 2'd0) & ~rst;
    assign resp_data  = fifo_data[rd_ptr];
    assign resp_id    = fifo_id[rd_ptr];
    assign resp_err   = resp_valid & fifo_err[rd_ptr];

endmodule

// File: tb/tb_bfpu_sched.sv
// tb/tb_bfpu_sched.sv - directed table-driven testbench for bfpu_sched
module tb_bfpu_sched;

    localparam int NUM_REQ = 4;
    localparam int BVS     = 64;
    localparam int TAG_W   = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BVS-1:0]    req_in_1;
    logic [NUM_REQ*BVS-1:0]    req_in_2;
    logic [NUM_REQ*3-1:0]      req_opcode;
    logic [NUM_REQ-1:0]        req_choice;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [BVS-1:0]            resp_data;
    logic [TAG_W-1:0]          resp_id;
    logic                      resp_err;

    bfpu_sched #(
        .NUM_REQ      (NUM_REQ),
        .BIT_VEC_SIZE (BVS),
        .TAG_W        (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_in_1   (req_in_1),
        .req_in_2   (req_in_2),
        .req_opcode (req_opcode),
        .req_choice (req_choice),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         id;
        logic [2:0] op;
        logic       ch;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];
    int   exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic ch,
                           input logic [63:0] a, input logic [63:0] b);
        req_in_1[i*BVS +: BVS] = a;
        req_in_2[i*BVS +: BVS] = b;
        req_opcode[i*3 +: 3]   = op;
        req_choice[i]          = ch;
        req_valid[i]           = 1'b1;
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'(i + 1) * 64'h0000_0000_0001_1111;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic run_single(input vec_t v);
        int acc;
        int got;
        acc = -1;
        got = 0;
        req_valid = '0;
        set_req(v.id, v.op, v.ch, v.a, v.b);
        #1;
        for (int t = 0; t < 20; t++) begin
            if (req_ready[v.id]) begin
                acc = cyc;
                break;
            end
            tick();
        end
        check("single_accept", 64'(acc >= 0), 64'd1);
        check("single_grant", 64'(req_ready), 64'(4'b0001 << v.id));
        tick();
        req_valid = '0;
        #1;
        for (int t = 0; t < 10; t++) begin
            if (resp_valid) begin
                got = 1;
                break;
            end
            tick();
        end
        check("single_resp", 64'(got), 64'd1);
        if (got == 1) begin
            check("single_latency", 64'(cyc - acc), 64'd2);
            check("single_data", resp_data, v.exp_data);
            check("single_id", 64'(resp_id), 64'(v.id));
            check("single_err", 64'(resp_err), 64'(v.exp_err));
        end
        tick();
    endtask

    task automatic drain_expect(input int n);
        int got;
        int id;
        got = 0;
        for (int t = 0; t < 10; t++) begin
            if (resp_valid) begin
                id = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                check("drain_id", 64'(resp_id), 64'(id));
                check("drain_data", resp_data, pat(id));
                got++;
            end
            tick();
        end
        check("drain_count", 64'(got), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int accepts;
        int id;

        vecs[0] = '{2, 3'b100, 1'b0, 64'hF0F0, 64'h0FF0, 64'hFF00, 1'b0};
        vecs[1] = '{0, 3'b001, 1'b0, 64'h00F0, 64'h0F00, 64'h0FF0, 1'b0};
        vecs[2] = '{1, 3'b010, 1'b0, 64'hFF00, 64'h0FF0, 64'h0F00, 1'b0};
        vecs[3] = '{3, 3'b011, 1'b0, 64'hFF00, 64'h0FF0, 64'hF000, 1'b0};
        vecs[4] = '{0, 3'b000, 1'b1, 64'h1,    64'h2,    64'h2,    1'b0};
        vecs[5] = '{0, 3'b000, 1'b0, 64'h1,    64'h2,    64'h1,    1'b0};
        vecs[6] = '{1, 3'b110, 1'b0, 64'hFFFF, 64'hFFFF, 64'h0,    1'b1};
        vecs[7] = '{1, 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_0000,
                    64'hFFFF_FFFF_0000_FFFF, 1'b0};

        rst        = 1'b1;
        req_valid  = '0;
        req_in_1   = '0;
        req_in_2   = '0;
        req_opcode = '0;
        req_choice = '0;
        resp_ready = 1'b1;

        // Reset state with requests pending, then first accept right after release.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'b001, 1'b0, pat(i), 64'h0);
        tick();
        tick();
        tick();
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_resp_err", 64'(resp_err), 64'h0);
        rst = 1'b0;
        #1;

        // Fairness: all four requesting, consumer always ready.
        for (int k = 0; k < 8; k++) begin
            check("fair_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            exp_q.push_back(k % 4);
            if (resp_valid) begin
                id = exp_q.pop_front();
                check("fair_resp_id", 64'(resp_id), 64'(id));
                check("fair_resp_data", resp_data, pat(id));
            end
            tick();
        end
        req_valid = '0;
        #1;
        drain_expect(exp_q.size());

        // Individual operations, illegal opcode and recovery.
        foreach (vecs[i]) run_single(vecs[i]);

        // Backpressure: consumer stalled, continuous requests.
        resp_ready = 1'b0;
        exp_q.delete();
        accepts = 0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'b001, 1'b0, pat(i), 64'h0);
        #1;
        for (int t = 0; t < 6; t++) begin
            if (req_ready != '0) begin
                accepts++;
                exp_q.push_back(onehot_idx(req_ready));
            end
            tick();
        end
        check("bp_accepts", 64'(accepts), 64'd2);
        check("bp_ready_zero", 64'(req_ready), 64'h0);
        check("bp_resp_valid", 64'(resp_valid), 64'd1);
        req_valid  = '0;
        resp_ready = 1'b1;
        #1;
        drain_expect(2);

        // Reset while two results are buffered.
        resp_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'b001, 1'b0, pat(i), 64'h0);
        repeat (5) tick();
        req_valid = '0;
        tick();
        check("mid_buffered", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(resp_valid), 64'h0);
        rst = 1'b0;
        resp_ready = 1'b1;
        accepts = 0;
        for (int t = 0; t < 4; t++) begin
            if (resp_valid) accepts++;
            tick();
        end
        check("mid_no_stale", 64'(accepts), 64'h0);
        req_valid = 4'hF;
        #1;
        check("mid_rr_ptr", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bfpu_sched.md
BFPU_SCHED -- requirements
Module: bfpu_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one bfpu (legal 2..8).
REQ-002 Parameter BIT_VEC_SIZE, default from shared params package (64), operand/result width.
REQ-003 Parameter TAG_W, default $clog2(NUM_REQ), requester-id width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_in_1  input  NUM_REQ*BIT_VEC_SIZE  operand 1; slice i belongs to requester i.
REQ-008 req_in_2  input  NUM_REQ*BIT_VEC_SIZE  operand 2; slice i belongs to requester i.
REQ-009 req_opcode  input  NUM_REQ*3  opcode per requester (000 select, 001 OR, 010 AND, 011 ANDN, 100 XOR).
REQ-010 req_choice  input  NUM_REQ  select bit for opcode 000.
REQ-011 req_ready  output  NUM_REQ  one-hot or zero grant; request i is accepted in a cycle with req_valid[i] & req_ready[i].
REQ-012 resp_valid  output  1  result available.
REQ-013 resp_ready  input  1  consumer accepts result.
REQ-014 resp_data  output  BIT_VEC_SIZE  result.
REQ-015 resp_id  output  TAG_W  index of the requester that issued the result.
REQ-016 resp_err  output  1  result came from an illegal opcode (101..111).

Function
REQ-017 At most one request is accepted per cycle; req_ready is combinational from req_valid, rr_ptr and credit state.
REQ-018 Arbitration is round-robin: grant the lowest index i, searched cyclically starting at rr_ptr, with req_valid[i]=1; after an accept, rr_ptr <= (i+1) mod NUM_REQ; rr_ptr holds when nothing is accepted.
REQ-019 Accepted operands, opcode and choice drive one bfpu instance with valid_in_1=valid_in_2=1 in the accept cycle and 0 otherwise; the tag and an illegal-opcode flag are delayed one cycle alongside.
REQ-020 When bfpu valid_out=1, {data, tag, err} is written into a 2-entry result FIFO; if err=1 the written data is all-zeros.
REQ-021 Latency: a request accepted in cycle T appears at the FIFO head (resp_valid=1) no earlier than cycle T+2.
REQ-022 Results leave in accept order; the FIFO pops when resp_valid & resp_ready.
REQ-023 Credit rule: accept is allowed only if fifo_count + inflight - pop_this_cycle < 2, where inflight=1 while a bfpu operation is in its cycle; no FIFO overflow is possible.
REQ-024 FIFO full with resp_ready=0: req_ready is all-zero; req_valid may stay high without loss.
REQ-025 Simultaneous push and pop on a full FIFO: both occur and the count is unchanged.
REQ-026 Pop with an empty FIFO cannot happen (resp_valid=0); resp_data/resp_id/resp_err are don't-care while resp_valid=0.
REQ-027 An illegal opcode consumes a slot and returns resp_err=1 with resp_data=0; it never stalls the block.

Reset
REQ-028 During rst=1: req_ready=0, resp_valid=0, resp_err=0, rr_ptr=0, fifo_count=0, inflight=0; bfpu rst is driven from rst.
REQ-029 rst asserted mid-operation discards in-flight and buffered results; no response from before reset appears afterwards.
REQ-030 The first accept after reset deasserts may occur in the cycle after rst falls.

Structure
REQ-031 BIT_VEC_SIZE and the opcode encodings (OP_SEL, OP_OR, OP_AND, OP_ANDN, OP_XOR) live in the shared params package.
REQ-032 bfpu is instantiated unmodified as the single sub-module; the arbiter, credit logic and result FIFO are local to bfpu_sched.

Verification
REQ-033 Single request: req 2 issues XOR with in_1=0xF0F0, in_2=0x0FF0 -> one response, resp_data=0xFF00, resp_id=2, resp_err=0, 2 cycles after accept.
REQ-034 Fairness: all 4 req_valid held high with resp_ready=1 -> accept order 0,1,2,3,0,... one per cycle; resp_id follows the same order.
REQ-035 Backpressure: resp_ready=0 and continuous requests -> exactly 2 accepts, then req_ready=0; after resp_ready=1, results drain in order with no loss or duplication.
REQ-036 Illegal opcode: req 1 issues opcode 110 -> resp_err=1, resp_data=0, resp_id=1, and the next request completes normally.
REQ-037 Reset mid-stream: assert rst while 2 results are buffered -> resp_valid=0 the next cycle, rr_ptr=0, and no stale results after release.
REQ-038 Select op: opcode 000, choice=1, in_1=0x1, in_2=0x2 -> resp_data=0x2; with choice=0 -> resp_data=0x1.
